// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin over WIDTH clocks, LSB first.
// Result and borrow are registered on entry to DONE and held until the next DONE.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  logic             a0;
  logic             b0;
  logic             d_bit;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic             last;

  // One full-subtractor cell applied to the current LSBs.
  always_comb begin
    a0    = a_q[0];
    b0    = b_q[0];
    d_bit = a0 ^ b0 ^ br_q;
    br_d  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
    res_d = {d_bit, res_q[WIDTH-1:1]};
    last  = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          res_q <= res_d;
          cnt_q <= cnt_q + 1'b1;
          // The final bit lands in diff on the same edge it is computed.
          if (last) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): vector table,
// reset/ignored-start sequences and a randomized held-start stream.
module tb_serial_subtractor;

  localparam int W = 4;
  localparam int P = W + 2;
  localparam int NR = 60;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] ed;
    logic         eb;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_diff(input int x, input int y, input int c);
    int r;
    r = (x - y - c) % (1 << W);
    if (r < 0) r += (1 << W);
    return W'(r);
  endfunction

  function automatic logic ref_bout(input int x, input int y, input int c);
    return (x < y + c);
  endfunction

  // Full operation: accept, scramble inputs, check latency and result.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xc, input logic [W-1:0] ed,
                        input logic eb, input string tag);
    @(negedge clk);
    a = xa; b = xb; bin = xc; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".busy_acc"}, busy, 1);
    chk({tag, ".done_acc"}, done, 0);
    @(negedge clk);
    start = 1'b0; a = ~xa; b = ~xb; bin = ~xc;
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      chk({tag, ".done_early"}, done, 0);
    end
    @(posedge clk); #1;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".diff"}, diff, ed);
    chk({tag, ".bout"}, bout, eb);
    @(posedge clk); #1;
    chk({tag, ".done_clr"}, done, 0);
    chk({tag, ".busy_clr"}, busy, 0);
    chk({tag, ".diff_hold"}, diff, ed);
  endtask

  vec_t vt[6];
  logic [W-1:0] ra[NR];
  logic [W-1:0] rb[NR];
  logic         rc[NR];

  initial begin
    vt[0] = '{4'b1011, 4'b0100, 1'b0, 4'b0111, 1'b0};
    vt[1] = '{4'b0100, 4'b1011, 1'b0, 4'b1001, 1'b1};
    vt[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
    vt[3] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0};
    vt[4] = '{4'b1000, 4'b0111, 1'b1, 4'b0000, 1'b0};
    vt[5] = '{4'b0111, 4'b0111, 1'b1, 4'b1111, 1'b1};

    #12;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.diff", diff, 0);
    chk("rst.bout", bout, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(vt[i].a, vt[i].b, vt[i].bin, vt[i].ed, vt[i].eb,
             $sformatf("vec%0d", i));

    // start re-pulsed during RUN must not disturb the operation.
    @(negedge clk);
    a = 4'b1011; b = 4'b0100; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'b0001; b = 4'b0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W - 2; i++) @(posedge clk);
    #1;
    chk("ign.done", done, 1);
    chk("ign.diff", diff, 4'b0111);
    chk("ign.bout", bout, 0);
    @(posedge clk); #1;
    chk("ign.busy_clr", busy, 0);

    // Reset after the 2nd RUN edge: outputs clear without a clock edge.
    @(negedge clk);
    a = 4'b0100; b = 4'b1011; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.done", done, 0);
    chk("arst.diff", diff, 0);
    chk("arst.bout", bout, 0);
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      chk("arst.no_done", done, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(4'b1011, 4'b0100, 1'b0, 4'b0111, 1'b0, "post_rst");

    // Held start: accepts every P cycles (W RUN, DONE, one IDLE).
    begin
      logic [W-1:0] ed;
      logic         eb;
      ed = 4'b0111;
      eb = 1'b0;
      for (int k = 0; k < NR; k++) begin
        @(negedge clk);
        ra[k] = W'($urandom);
        rb[k] = W'($urandom);
        rc[k] = 1'($urandom);
        a = ra[k]; b = rb[k]; bin = rc[k]; start = 1'b1;
        @(posedge clk); #1;
        if (k % P == W) begin
          ed = ref_diff(ra[k-W], rb[k-W], rc[k-W]);
          eb = ref_bout(ra[k-W], rb[k-W], rc[k-W]);
        end
        chk($sformatf("rnd%0d.done", k), done, (k % P == W));
        chk($sformatf("rnd%0d.busy", k), busy, (k % P != P - 1));
        chk($sformatf("rnd%0d.diff", k), diff, ed);
        chk($sformatf("rnd%0d.bout", k), bout, eb);
      end
      start = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
